perm_arbiter: RTL and testbench
===============================

Name: perm_arbiter

Overview:
- Shares one permutation (perm) engine between N_REQ NoC interface requesters.
- Each transaction is one full 200-byte block: WORDS × 64-bit words pushed into the perm, then WORDS × 64-bit result words drained back to the same requester.
- The grant is locked for the whole block, including the return path. Requesters are served in round-robin order.
- Sits between the per-node noc_intf instances and the single perm engine, and owns its pushin/stopin and pushout/stopout handshakes.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- WORDS, 25, 64-bit words per block in each direction.
- TIMEOUT, 1024, max cycles in OUT state with no accepted output word before abort.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-low.
- req_pushin  input  N_REQ  per-requester input word valid; also serves as the request.
- req_firstin  input  N_REQ  per-requester first-word marker.
- req_din  input  64*N_REQ  per-requester input word; requester i at [64i+63:64i].
- req_stopin  output  N_REQ  per-requester back-pressure; 1 = word not accepted.
- req_pushout  output  N_REQ  per-requester result word valid.
- req_firstout  output  1  result first-word marker (shared).
- req_dout  output  64  result word (shared).
- req_stopout  input  N_REQ  per-requester result back-pressure.
- pushin  output  1  to perm.
- firstin  output  1  to perm.
- din  output  64  to perm.
- stopin  input  1  from perm.
- pushout  input  1  from perm.
- firstout  input  1  from perm.
- dout  input  64  from perm.
- stopout  output  1  to perm.
- grant  output  N_REQ  one-hot owner; 0 when idle.
- busy  output  1  state != IDLE.
- err_first  output  1  sticky; first accepted input word lacked firstin.
- err_timeout  output  1  sticky; OUT state aborted on TIMEOUT.

Behaviour:
- Reset (rst=0 at posedge clk):
  - state=IDLE, grant=0, last=N_REQ-1, word counter=0, timeout counter=0.
  - err_first=0, err_timeout=0.
  - Combinational outputs settle to idle values: pushin=0, stopout=1, req_stopin=all 1, req_pushout=0.
  - Reset mid-transfer discards the block; the perm is not flushed by this block.
- Handshakes:
  - Input word transfers when pushin && !stopin.
  - Output word transfers when pushout && !stopout.
- State IDLE:
  - All req_stopin=1.
  - If any req_pushin is set, pick the first requester at index (last+1..last+N_REQ) mod N_REQ.
  - Register it into grant; go to LOAD. Grant appears 1 cycle after the request.
- State LOAD (owner g):
  - Combinational pass-through: pushin=req_pushin[g], firstin=req_firstin[g], din=req_din[g], req_stopin[g]=stopin.
  - All other req_stopin=1. stopout=1.
  - Counter increments on each accepted word.
  - On the first accepted word (count 0) with firstin=0: set err_first. The word is still forwarded.
  - Accepted word with count == WORDS-1 → count=0, timeout counter=0, go to OUT.
- State OUT (owner g):
  - Pass-through: req_pushout[g]=pushout, req_firstout=firstout, req_dout=dout, stopout=req_stopout[g].
  - Other req_pushout=0. pushin=0. All req_stopin=1.
  - Counter increments on each accepted output word.
  - Accepted word with count == WORDS-1 → last=g, grant=0, go to IDLE.
  - Timeout counter increments every cycle with no accepted output word; it clears on an accepted word.
  - Timeout counter reaches TIMEOUT-1 → set err_timeout, last=g, grant=0, go to IDLE.
- Back-to-back: after returning to IDLE, the next grant is earliest 1 cycle later; no overlap of LOAD and OUT.
- A requester deasserting req_pushin mid-LOAD simply stalls; the grant is held.
- pushout arriving in IDLE or LOAD is ignored (stopout=1); this is not an error.
- Counters are $clog2(WORDS+1) and $clog2(TIMEOUT) bits wide, with no wrap inside a block.

Test Plan:
- Single requester:
  - Stimulus: req0 pushes 25 words 0x0..0x18, firstin on word 0; perm returns 25 words.
  - Required response: grant=01 the cycle after the first req_pushin; din matches the words in order; req_pushout[0] carries all 25 results; busy drops after the 25th; err flags stay 0.
- Round-robin:
  - Stimulus: req0 and req1 both request from reset.
  - Required response: order is req0 then req1. With req0 requesting again while req1 is served, the next grant is req0 (last=1).
- Back-pressure:
  - Stimulus: stopin=1 for 3 cycles mid-LOAD; req_stopout[0]=1 for 4 cycles mid-OUT.
  - Required response: exactly 25 words transfer each way; req_stopin[0] and stopout mirror the stalls; no duplicated or dropped words.
- Non-owner isolation:
  - Stimulus: req1 pushes while req0 owns the perm.
  - Required response: req_stopin[1]=1 and req_pushout[1]=0 throughout req0's block.
- Errors:
  - Stimulus: first word sent with firstin=0.
  - Required response: err_first=1, and the block still completes.
  - Stimulus: TIMEOUT=16 with the perm never pushing out.
  - Required response: err_timeout=1 and state returns to IDLE after 16 OUT cycles.
- Reset mid-block:
  - Stimulus: assert rst=0 for one cycle after word 10 of LOAD.
  - Required response: grant=0, busy=0, req_stopin all 1. The next request starts a fresh block with count=0.

Source files
------------

// File: rtl/perm_arbiter.sv
// perm_arbiter: shares one permutation engine between N_REQ requesters.
// A requester that wins arbitration owns the engine for one whole block:
// WORDS input words are forwarded into the engine (LOAD), then WORDS result
// words are returned to that same requester (OUT). Ownership rotates
// round-robin. An OUT phase that sees no result word accepted for TIMEOUT
// cycles is abandoned and flagged.
//
// Ports:
//   clk, rst          clock; synchronous active-low reset
//   req_pushin/firstin/din/stopin     per-requester input handshake
//   req_pushout/stopout               per-requester result handshake
//   req_firstout, req_dout            shared result marker and data
//   pushin/firstin/din/stopin         input handshake toward the engine
//   pushout/firstout/dout/stopout     result handshake from the engine
//   grant             one-hot current owner, 0 when idle
//   busy              a block is in progress
//   err_first         sticky: first accepted word of a block lacked firstin
//   err_timeout       sticky: an OUT phase was abandoned on timeout
module perm_arbiter #(
    parameter int N_REQ   = 2,
    parameter int WORDS   = 25,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_pushin,
    input  logic [N_REQ-1:0]     req_firstin,
    input  logic [64*N_REQ-1:0]  req_din,
    output logic [N_REQ-1:0]     req_stopin,
    output logic [N_REQ-1:0]     req_pushout,
    output logic                 req_firstout,
    output logic [63:0]          req_dout,
    input  logic [N_REQ-1:0]     req_stopout,
    output logic                 pushin,
    output logic                 firstin,
    output logic [63:0]          din,
    input  logic                 stopin,
    input  logic                 pushout,
    input  logic                 firstout,
    input  logic [63:0]          dout,
    output logic                 stopout,
    output logic [N_REQ-1:0]     grant,
    output logic                 busy,
    output logic                 err_first,
    output logic                 err_timeout
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(WORDS + 1);
    localparam int TMO_W = $clog2(TIMEOUT);

    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_INIT  = IDX_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [N_REQ-1:0]   grant_r, grant_nxt_s;
    logic [IDX_W-1:0]   owner_r, owner_nxt_s;
    logic [IDX_W-1:0]   last_r, last_nxt_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic [TMO_W-1:0]   tmo_r, tmo_nxt_s;
    logic               err_first_r, err_first_nxt_s;
    logic               err_timeout_r, err_timeout_nxt_s;
    logic [IDX_W-1:0]   pick_s;
    logic               pick_vld_s;
    logic               in_acc_s;
    logic               out_acc_s;
    logic [63:0]        req_din_a_s [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_din
        assign req_din_a_s[gi] = req_din[64*gi +: 64];
    end

    assign in_acc_s    = pushin && !stopin;
    assign out_acc_s   = pushout && !stopout;
    assign grant       = grant_r;
    assign busy        = (state_r != ST_IDLE);
    assign err_first   = err_first_r;
    assign err_timeout = err_timeout_r;

    // Round-robin pick: lowest offset k in 1..N_REQ above last_r wins, so the
    // loop walks offsets downward and the last hit (smallest k) is kept.
    always_comb begin
        int idx_v;
        idx_v      = 0;
        pick_s     = last_r;
        pick_vld_s = 1'b0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx_v = (int'(last_r) + k) % N_REQ;
            if (req_pushin[IDX_W'(idx_v)]) begin
                pick_s     = IDX_W'(idx_v);
                pick_vld_s = 1'b1;
            end else begin
                pick_s     = pick_s;
                pick_vld_s = pick_vld_s;
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            grant_r       <= {N_REQ{1'b0}};
            owner_r       <= {IDX_W{1'b0}};
            last_r        <= IDX_INIT;
            cnt_r         <= {CNT_W{1'b0}};
            tmo_r         <= {TMO_W{1'b0}};
            err_first_r   <= 1'b0;
            err_timeout_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            grant_r       <= grant_nxt_s;
            owner_r       <= owner_nxt_s;
            last_r        <= last_nxt_s;
            cnt_r         <= cnt_nxt_s;
            tmo_r         <= tmo_nxt_s;
            err_first_r   <= err_first_nxt_s;
            err_timeout_r <= err_timeout_nxt_s;
        end
    end

    // Next-state logic: grant, word counting, timeout and error flags.
    always_comb begin
        state_nxt_s       = state_r;
        grant_nxt_s       = grant_r;
        owner_nxt_s       = owner_r;
        last_nxt_s        = last_r;
        cnt_nxt_s         = cnt_r;
        tmo_nxt_s         = tmo_r;
        err_first_nxt_s   = err_first_r;
        err_timeout_nxt_s = err_timeout_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_vld_s) begin
                    state_nxt_s = ST_LOAD;
                    owner_nxt_s = pick_s;
                    grant_nxt_s = {{(N_REQ-1){1'b0}}, 1'b1} << pick_s;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (in_acc_s) begin
                    // A missing first marker is recorded but the word still goes through.
                    if ((cnt_r == {CNT_W{1'b0}}) && !firstin) begin
                        err_first_nxt_s = 1'b1;
                    end else begin
                        err_first_nxt_s = err_first_r;
                    end
                    if (cnt_r == LAST_WORD) begin
                        cnt_nxt_s   = {CNT_W{1'b0}};
                        tmo_nxt_s   = {TMO_W{1'b0}};
                        state_nxt_s = ST_OUT;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_W'(1);
                    end
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            ST_OUT: begin
                if (out_acc_s) begin
                    tmo_nxt_s = {TMO_W{1'b0}};
                    if (cnt_r == LAST_WORD) begin
                        cnt_nxt_s   = {CNT_W{1'b0}};
                        last_nxt_s  = owner_r;
                        grant_nxt_s = {N_REQ{1'b0}};
                        state_nxt_s = ST_IDLE;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_W'(1);
                    end
                end else if (tmo_r == TMO_LAST) begin
                    err_timeout_nxt_s = 1'b1;
                    cnt_nxt_s         = {CNT_W{1'b0}};
                    tmo_nxt_s         = {TMO_W{1'b0}};
                    last_nxt_s        = owner_r;
                    grant_nxt_s       = {N_REQ{1'b0}};
                    state_nxt_s       = ST_IDLE;
                end else begin
                    tmo_nxt_s = tmo_r + TMO_W'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                grant_nxt_s = {N_REQ{1'b0}};
                cnt_nxt_s   = {CNT_W{1'b0}};
                tmo_nxt_s   = {TMO_W{1'b0}};
            end
        endcase
    end

    // Output steering: connect the owner to the engine in the active direction only.
    always_comb begin
        pushin       = 1'b0;
        firstin      = 1'b0;
        din          = 64'd0;
        stopout      = 1'b1;
        req_stopin   = {N_REQ{1'b1}};
        req_pushout  = {N_REQ{1'b0}};
        req_firstout = 1'b0;
        req_dout     = 64'd0;
        case (state_r)
            ST_LOAD: begin
                pushin              = req_pushin[owner_r];
                firstin             = req_firstin[owner_r];
                din                 = req_din_a_s[owner_r];
                req_stopin[owner_r] = stopin;
            end
            ST_OUT: begin
                req_pushout[owner_r] = pushout;
                req_firstout         = firstout;
                req_dout             = dout;
                stopout              = req_stopout[owner_r];
            end
            default: begin
                pushin = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_perm_arbiter.sv
`timescale 1ns/1ps
module tb_perm_arbiter;
    localparam int N   = 2;
    localparam int W   = 25;
    localparam int TMO = 16;
    localparam logic [63:0] KEY = 64'hC3A5_5A3C_0F0F_F0F0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic [1:0] req_pushin, req_firstin, req_stopin, req_pushout, req_stopout;
    logic [127:0] req_din;
    logic req_firstout;
    logic [63:0] req_dout;
    logic pushin, firstin, stopin, pushout, firstout, stopout;
    logic [63:0] din, dout;
    logic [1:0] grant;
    logic busy, err_first, err_timeout;

    // requester-side drive variables
    logic pi0, pi1, fi0, fi1;
    logic [63:0] d0, d1;
    assign req_pushin  = {pi1, pi0};
    assign req_firstin = {fi1, fi0};
    assign req_din     = {d1, d0};

    perm_arbiter #(.N_REQ(N), .WORDS(W), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_pushin(req_pushin), .req_firstin(req_firstin), .req_din(req_din),
        .req_stopin(req_stopin), .req_pushout(req_pushout), .req_firstout(req_firstout),
        .req_dout(req_dout), .req_stopout(req_stopout),
        .pushin(pushin), .firstin(firstin), .din(din), .stopin(stopin),
        .pushout(pushout), .firstout(firstout), .dout(dout), .stopout(stopout),
        .grant(grant), .busy(busy), .err_first(err_first), .err_timeout(err_timeout)
    );

    int checks = 0;
    int errors = 0;

    logic [64:0] src0_q[$], src1_q[$];
    logic [64:0] exp0_q[$], exp1_q[$];
    logic [64:0] rx0_q[$], rx1_q[$];
    logic [64:0] perm_log[$];
    logic [63:0] perm_buf[$], res_q[$];
    logic [1:0]  grant_log[$];
    logic [1:0]  grant_seen = 2'b00;
    int res_idx = 0;
    int iso_viol = 0;
    bit perm_out_en = 1'b1;
    bit rand_bp = 1'b0;
    bit gap_en = 1'b0;
    bit tb_stall = 1'b0;
    logic [1:0] tb_stopout = 2'b00;

    // Requester 0: presents its queue head, pops on acceptance, random gaps mid-block.
    initial begin : drv0
        bit acc;
        pi0 = 1'b0; fi0 = 1'b0; d0 = 64'd0;
        forever begin
            @(negedge clk);
            acc = pi0 && !req_stopin[0];
            @(posedge clk); #1;
            if (acc && src0_q.size() > 0) src0_q.delete(0);
            if (src0_q.size() > 0 && !(gap_en && !src0_q[0][64] && $urandom_range(3) == 0)) begin
                pi0 = 1'b1; fi0 = src0_q[0][64]; d0 = src0_q[0][63:0];
            end else begin
                pi0 = 1'b0; fi0 = 1'b0; d0 = 64'd0;
            end
        end
    end

    // Requester 1: same behaviour as requester 0.
    initial begin : drv1
        bit acc;
        pi1 = 1'b0; fi1 = 1'b0; d1 = 64'd0;
        forever begin
            @(negedge clk);
            acc = pi1 && !req_stopin[1];
            @(posedge clk); #1;
            if (acc && src1_q.size() > 0) src1_q.delete(0);
            if (src1_q.size() > 0 && !(gap_en && !src1_q[0][64] && $urandom_range(3) == 0)) begin
                pi1 = 1'b1; fi1 = src1_q[0][64]; d1 = src1_q[0][63:0];
            end else begin
                pi1 = 1'b0; fi1 = 1'b0; d1 = 64'd0;
            end
        end
    end

    // Perm engine model (result = word ^ KEY, released once a full block arrived) and monitors.
    initial begin : env
        bit oacc;
        pushout = 1'b0; firstout = 1'b0; dout = 64'd0;
        stopin = 1'b0; req_stopout = 2'b00;
        forever begin
            @(negedge clk);
            if (pushin && !stopin) begin
                perm_log.push_back({firstin, din});
                perm_buf.push_back(din);
                if (perm_buf.size() == W) begin
                    foreach (perm_buf[k]) res_q.push_back(perm_buf[k] ^ KEY);
                    perm_buf.delete();
                end
            end
            oacc = pushout && !stopout;
            if (req_pushout[0] && !req_stopout[0]) rx0_q.push_back({req_firstout, req_dout});
            if (req_pushout[1] && !req_stopout[1]) rx1_q.push_back({req_firstout, req_dout});
            if (grant !== grant_seen) begin
                if (grant !== 2'b00) grant_log.push_back(grant);
                grant_seen = grant;
            end
            if (grant[0] && (req_stopin[1] !== 1'b1 || req_pushout[1] !== 1'b0)) iso_viol++;
            @(posedge clk); #1;
            if (oacc && res_q.size() > 0) begin
                res_q.delete(0);
                res_idx++;
            end
            pushout  = perm_out_en && (res_q.size() > 0);
            dout     = (res_q.size() > 0) ? res_q[0] : 64'd0;
            firstout = pushout && ((res_idx % W) == 0);
            if (rand_bp) begin
                stopin      = ($urandom_range(3) == 0);
                req_stopout = 2'($urandom_range(3));
            end else begin
                stopin      = tb_stall;
                req_stopout = tb_stopout;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    // Queue one block for requester r; expected results are what the engine returns.
    task automatic send_block(input int r, input bit use_first, input bit seq);
        logic [63:0] w;
        for (int k = 0; k < W; k++) begin
            w = seq ? 64'(k) : {$urandom, $urandom};
            if (r == 0) begin
                src0_q.push_back({use_first && (k == 0), w});
                exp0_q.push_back({(k == 0), w ^ KEY});
            end else begin
                src1_q.push_back({use_first && (k == 0), w});
                exp1_q.push_back({(k == 0), w ^ KEY});
            end
        end
    endtask

    task automatic clear_logs();
        rx0_q.delete(); rx1_q.delete(); exp0_q.delete(); exp1_q.delete();
        perm_log.delete(); grant_log.delete();
    endtask

    task automatic wait_done(input int n0, input int n1, input string name);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 4000 && !ok; c++) begin
            tick();
            ok = (rx0_q.size() >= n0) && (rx1_q.size() >= n1) && !busy &&
                 (src0_q.size() == 0) && (src1_q.size() == 0);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_done: rx0=%0d rx1=%0d busy=%b, required rx0=%0d rx1=%0d busy=0",
                     name, rx0_q.size(), rx1_q.size(), busy, n0, n1);
        end
    endtask

    function automatic int rr_next(input int last, input bit [1:0] mask);
        for (int k = 1; k <= N; k++) begin
            if (mask[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        checks += 8;
        if (grant !== 2'b00)      begin errors++; $display("FAIL rst_grant: got %b want 00", grant); end
        if (busy !== 1'b0)        begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (pushin !== 1'b0)      begin errors++; $display("FAIL rst_pushin: got %b want 0", pushin); end
        if (stopout !== 1'b1)     begin errors++; $display("FAIL rst_stopout: got %b want 1", stopout); end
        if (req_stopin !== 2'b11) begin errors++; $display("FAIL rst_req_stopin: got %b want 11", req_stopin); end
        if (req_pushout !== 2'b00) begin errors++; $display("FAIL rst_req_pushout: got %b want 00", req_pushout); end
        if (err_first !== 1'b0)   begin errors++; $display("FAIL rst_err_first: got %b want 0", err_first); end
        if (err_timeout !== 1'b0) begin errors++; $display("FAIL rst_err_timeout: got %b want 0", err_timeout); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        clear_logs();
        send_block(0, 1'b1, 1'b1);
        tick();
        checks++;
        if (grant !== 2'b00) begin errors++; $display("FAIL single_grant_early: got %b want 00", grant); end
        tick();
        checks++;
        if (grant !== 2'b01) begin errors++; $display("FAIL single_grant: got %b want 01", grant); end
        wait_done(W, 0, "single");
        checks++;
        if (perm_log.size() !== W) begin errors++; $display("FAIL single_din_count: got %0d want %0d", perm_log.size(), W); end
        for (int k = 0; k < perm_log.size() && k < W; k++) begin
            checks++;
            if (perm_log[k] !== {(k == 0), 64'(k)}) begin
                errors++; $display("FAIL single_din[%0d]: got %h want %h", k, perm_log[k], {(k == 0), 64'(k)});
            end
        end
        for (int k = 0; k < rx0_q.size() && k < exp0_q.size(); k++) begin
            checks++;
            if (rx0_q[k] !== exp0_q[k]) begin errors++; $display("FAIL single_rx[%0d]: got %h want %h", k, rx0_q[k], exp0_q[k]); end
        end
        checks += 3;
        if (rx1_q.size() !== 0) begin errors++; $display("FAIL single_rx1: got %0d words want 0", rx1_q.size()); end
        if (err_first !== 1'b0) begin errors++; $display("FAIL single_err_first: got %b want 0", err_first); end
        if (err_timeout !== 1'b0) begin errors++; $display("FAIL single_err_timeout: got %b want 0", err_timeout); end
    endtask

    task automatic test_round_robin();
        int last, g;
        int pend [2];
        logic [1:0] exp_g[$];
        rst = 1'b0; tick(); rst = 1'b1;
        clear_logs();
        gap_en = 1'b1;
        send_block(0, 1'b1, 1'b0); send_block(0, 1'b1, 1'b0); send_block(1, 1'b1, 1'b0);
        last = N - 1; pend[0] = 2; pend[1] = 1;
        while (pend[0] + pend[1] > 0) begin
            g = rr_next(last, {pend[1] > 0, pend[0] > 0});
            exp_g.push_back(2'b01 << g);
            pend[g]--; last = g;
        end
        wait_done(2 * W, W, "rr");
        gap_en = 1'b0;
        checks++;
        if (grant_log.size() !== exp_g.size()) begin errors++; $display("FAIL rr_count: got %0d grants want %0d", grant_log.size(), exp_g.size()); end
        for (int k = 0; k < grant_log.size() && k < exp_g.size(); k++) begin
            checks++;
            if (grant_log[k] !== exp_g[k]) begin errors++; $display("FAIL rr_order[%0d]: got %b want %b", k, grant_log[k], exp_g[k]); end
        end
        for (int k = 0; k < rx1_q.size() && k < exp1_q.size(); k++) begin
            checks++;
            if (rx1_q[k] !== exp1_q[k]) begin errors++; $display("FAIL rr_rx1[%0d]: got %h want %h", k, rx1_q[k], exp1_q[k]); end
        end
    endtask

    task automatic test_backpressure();
        int snap;
        bit seen;
        clear_logs();
        send_block(0, 1'b1, 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin tick(); seen = (perm_log.size() >= 10); end
        tb_stall = 1'b1;
        tick();
        snap = perm_log.size();
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (req_stopin[0] !== 1'b1) begin errors++; $display("FAIL bp_stopin[%0d]: got %b want 1", c, req_stopin[0]); end
            if (c < 2) tick();
        end
        tb_stall = 1'b0;
        tick();
        checks++;
        if (perm_log.size() !== snap) begin errors++; $display("FAIL bp_in_stall: got %0d words want %0d", perm_log.size(), snap); end
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin tick(); seen = (rx0_q.size() >= 10); end
        tb_stopout = 2'b01;
        tick();
        snap = rx0_q.size();
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (stopout !== 1'b1) begin errors++; $display("FAIL bp_stopout[%0d]: got %b want 1", c, stopout); end
            if (c < 3) tick();
        end
        tb_stopout = 2'b00;
        tick();
        checks++;
        if (rx0_q.size() !== snap) begin errors++; $display("FAIL bp_out_stall: got %0d words want %0d", rx0_q.size(), snap); end
        wait_done(W, 0, "bp");
        checks += 2;
        if (perm_log.size() !== W) begin errors++; $display("FAIL bp_in_count: got %0d want %0d", perm_log.size(), W); end
        if (rx0_q.size() !== W) begin errors++; $display("FAIL bp_out_count: got %0d want %0d", rx0_q.size(), W); end
        for (int k = 0; k < rx0_q.size() && k < exp0_q.size(); k++) begin
            checks++;
            if (rx0_q[k] !== exp0_q[k]) begin errors++; $display("FAIL bp_rx[%0d]: got %h want %h", k, rx0_q[k], exp0_q[k]); end
        end
    endtask

    task automatic test_isolation();
        bit seen;
        clear_logs();
        send_block(0, 1'b1, 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin tick(); seen = (grant === 2'b01); end
        checks++;
        if (!seen) begin errors++; $display("FAIL iso_grant0: got %b want 01", grant); end
        iso_viol = 0;
        send_block(1, 1'b1, 1'b0);
        wait_done(W, W, "iso");
        checks += 2;
        if (iso_viol !== 0) begin errors++; $display("FAIL iso_viol: got %0d cycles want 0", iso_viol); end
        if (grant_log.size() !== 2 || grant_log[grant_log.size()-1] !== 2'b10) begin
            errors++; $display("FAIL iso_order: got %0d grants want 2 ending 10", grant_log.size());
        end
        for (int k = 0; k < rx1_q.size() && k < exp1_q.size(); k++) begin
            checks++;
            if (rx1_q[k] !== exp1_q[k]) begin errors++; $display("FAIL iso_rx1[%0d]: got %h want %h", k, rx1_q[k], exp1_q[k]); end
        end
    endtask

    task automatic test_random();
        int last, g;
        int pend [2];
        logic [1:0] exp_g[$];
        clear_logs();
        rand_bp = 1'b1; gap_en = 1'b1;
        for (int b = 0; b < 3; b++) begin send_block(0, 1'b1, 1'b0); send_block(1, 1'b1, 1'b0); end
        last = 1; pend[0] = 3; pend[1] = 3;
        while (pend[0] + pend[1] > 0) begin
            g = rr_next(last, {pend[1] > 0, pend[0] > 0});
            exp_g.push_back(2'b01 << g);
            pend[g]--; last = g;
        end
        wait_done(3 * W, 3 * W, "rand");
        rand_bp = 1'b0; gap_en = 1'b0;
        tick();
        checks += 2;
        if (grant_log.size() !== exp_g.size()) begin errors++; $display("FAIL rand_grants: got %0d want %0d", grant_log.size(), exp_g.size()); end
        if (err_timeout !== 1'b0) begin errors++; $display("FAIL rand_err_timeout: got %b want 0", err_timeout); end
        for (int k = 0; k < grant_log.size() && k < exp_g.size(); k++) begin
            checks++;
            if (grant_log[k] !== exp_g[k]) begin errors++; $display("FAIL rand_order[%0d]: got %b want %b", k, grant_log[k], exp_g[k]); end
        end
        for (int k = 0; k < rx0_q.size() && k < exp0_q.size(); k++) begin
            checks++;
            if (rx0_q[k] !== exp0_q[k]) begin errors++; $display("FAIL rand_rx0[%0d]: got %h want %h", k, rx0_q[k], exp0_q[k]); end
        end
        for (int k = 0; k < rx1_q.size() && k < exp1_q.size(); k++) begin
            checks++;
            if (rx1_q[k] !== exp1_q[k]) begin errors++; $display("FAIL rand_rx1[%0d]: got %h want %h", k, rx1_q[k], exp1_q[k]); end
        end
    endtask

    task automatic test_err_first();
        clear_logs();
        checks++;
        if (err_first !== 1'b0) begin errors++; $display("FAIL errf_before: got %b want 0", err_first); end
        send_block(0, 1'b0, 1'b0);
        wait_done(W, 0, "errf");
        checks += 2;
        if (err_first !== 1'b1) begin errors++; $display("FAIL errf_flag: got %b want 1", err_first); end
        if (rx0_q.size() !== W) begin errors++; $display("FAIL errf_count: got %0d want %0d", rx0_q.size(), W); end
        for (int k = 0; k < rx0_q.size() && k < exp0_q.size(); k++) begin
            checks++;
            if (rx0_q[k] !== exp0_q[k]) begin errors++; $display("FAIL errf_rx[%0d]: got %h want %h", k, rx0_q[k], exp0_q[k]); end
        end
    endtask

    task automatic test_timeout();
        int cyc;
        bit seen;
        clear_logs();
        perm_out_en = 1'b0;
        send_block(0, 1'b1, 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin tick(); seen = busy && (stopout === 1'b0); end
        checks += 2;
        if (!seen) begin errors++; $display("FAIL tmo_enter_out: got busy=%b stopout=%b want OUT", busy, stopout); end
        if (err_timeout !== 1'b0) begin errors++; $display("FAIL tmo_before: got %b want 0", err_timeout); end
        cyc = 0;
        for (int c = 0; c < 60 && busy; c++) begin
            if (stopout === 1'b0) cyc++;
            tick();
        end
        checks += 4;
        if (cyc !== TMO) begin errors++; $display("FAIL tmo_cycles: got %0d want %0d", cyc, TMO); end
        if (err_timeout !== 1'b1) begin errors++; $display("FAIL tmo_flag: got %b want 1", err_timeout); end
        if (busy !== 1'b0) begin errors++; $display("FAIL tmo_busy: got %b want 0", busy); end
        if (grant !== 2'b00) begin errors++; $display("FAIL tmo_grant: got %b want 00", grant); end
        res_q.delete(); res_idx = 0;
        perm_out_en = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        bit seen;
        clear_logs();
        send_block(0, 1'b1, 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin tick(); seen = (perm_log.size() >= 11); end
        rst = 1'b0;
        src0_q.delete();
        tick();
        rst = 1'b1;
        checks += 5;
        if (grant !== 2'b00) begin errors++; $display("FAIL rmid_grant: got %b want 00", grant); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
        if (req_stopin !== 2'b11) begin errors++; $display("FAIL rmid_req_stopin: got %b want 11", req_stopin); end
        if (err_first !== 1'b0) begin errors++; $display("FAIL rmid_err_first: got %b want 0", err_first); end
        if (err_timeout !== 1'b0) begin errors++; $display("FAIL rmid_err_timeout: got %b want 0", err_timeout); end
        clear_logs();
        perm_buf.delete();
        send_block(0, 1'b1, 1'b0);
        wait_done(W, 0, "rmid");
        checks += 2;
        if (perm_log.size() !== W) begin errors++; $display("FAIL rmid_in_count: got %0d want %0d", perm_log.size(), W); end
        if (rx0_q.size() !== W) begin errors++; $display("FAIL rmid_out_count: got %0d want %0d", rx0_q.size(), W); end
        for (int k = 0; k < rx0_q.size() && k < exp0_q.size(); k++) begin
            checks++;
            if (rx0_q[k] !== exp0_q[k]) begin errors++; $display("FAIL rmid_rx[%0d]: got %h want %h", k, rx0_q[k], exp0_q[k]); end
        end
    endtask

    initial begin : main
        rst = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_isolation();
        test_random();
        test_err_first();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
